// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues a req/ack transaction to a variable-latency data memory,
// freezes the pipeline until completion, and raises a sticky error if the memory never answers.
module mem_access_ctrl #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int ADDR_BASE      = 1024,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_r_en_in,
  input  logic                      mem_w_en_in,
  input  logic                      wb_en_in,
  input  logic [REG_FILE_DEPTH-1:0] dest_in,
  input  logic [WORD_WIDTH-1:0]     alu_res_in,
  input  logic [WORD_WIDTH-1:0]     val_rm_in,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [WORD_WIDTH-1:0]     mem_wdata,
  input  logic [WORD_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ack,
  output logic                      freeze,
  output logic                      wb_en_out,
  output logic                      mem_r_en_out,
  output logic [REG_FILE_DEPTH-1:0] dest_out,
  output logic [WORD_WIDTH-1:0]     alu_res_out,
  output logic [WORD_WIDTH-1:0]     mem_data_out,
  output logic                      mem_err
);

  // state | meaning
  // IDLE  | no transaction; a new access launches the request and freezes
  // WAIT  | request outstanding, waiting for ack or timeout
  // DONE  | transaction finished; pipeline released for one edge
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             timeout_hit;
  logic             freeze_c;

  assign access      = mem_r_en_in | mem_w_en_in;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (access) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_ack || timeout_hit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    freeze_c = 1'b0;
    case (state)
      ST_IDLE: freeze_c = access;
      ST_WAIT: freeze_c = 1'b1;
      default: freeze_c = 1'b0;
    endcase
  end

  // Held inputs stay asserted during reset, so gate freeze to release the pipeline at once.
  assign freeze       = freeze_c & rst_n;
  assign wb_en_out    = wb_en_in & ~freeze;
  assign mem_r_en_out = mem_r_en_in & ~freeze;
  assign dest_out     = dest_in;
  assign alu_res_out  = alu_res_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_data_out <= '0;
      mem_err      <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            mem_addr  <= ADDR_WIDTH'((alu_res_in - WORD_WIDTH'(ADDR_BASE)) >> 2);
            mem_wdata <= val_rm_in;
            mem_we    <= ~mem_r_en_in;
            mem_req   <= 1'b1;
            cnt       <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            if (!mem_we) mem_data_out <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if (timeout_hit) begin
            mem_req      <= 1'b0;
            mem_err      <= 1'b1;
            mem_data_out <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: load, store, non-memory op, timeout, reset mid-wait,
// and simultaneous read/write request, with hand-computed expectations.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        freeze, wb_en_out, mem_r_en_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  int          frz, reqc;
  logic [15:0] addr_seen;
  logic        we_seen;
  logic [31:0] wd_seen;
  int          req_seen;

  mem_access_ctrl #(
    .WORD_WIDTH(32), .REG_FILE_DEPTH(4), .ADDR_WIDTH(16), .ADDR_BASE(1024), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .dest_in(dest_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .freeze(freeze), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .dest_out(dest_out), .alu_res_out(alu_res_out), .mem_data_out(mem_data_out),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_inputs();
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    wb_en_in    = 1'b0;
    dest_in     = '0;
    alu_res_in  = '0;
    val_rm_in   = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
  endtask

  // Called at posedge+1 with the request already on the inputs; ack_wait counts WAIT cycles
  // before the ack cycle (negative = never ack). Returns at posedge+1 after the DONE edge.
  task automatic run_txn(input int ack_wait, input logic [31:0] rdata,
                         output int f_cnt, output int r_cnt, output logic [15:0] a_seen,
                         output logic w_seen, output logic [31:0] d_seen);
    logic f;
    f_cnt = 0; r_cnt = 0; a_seen = '0; w_seen = 1'b0; d_seen = '0;
    for (int c = 0; c < 40; c++) begin
      mem_ack   = (c == ack_wait + 1);
      mem_rdata = rdata;
      @(negedge clk);
      f = freeze;
      if (f) f_cnt++;
      if (mem_req) begin
        r_cnt++;
        a_seen = mem_addr;
        w_seen = mem_we;
        d_seen = mem_wdata;
      end
      @(posedge clk); #1;
      if (!f) break;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_freeze", 32'(freeze), 32'd0);
    check_val("rst_mem_err", 32'(mem_err), 32'd0);
    check_val("rst_data_out", mem_data_out, 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Load, ack in third WAIT cycle
    mem_r_en_in = 1'b1; wb_en_in = 1'b1; dest_in = 4'd5; alu_res_in = 32'd1032;
    run_txn(2, 32'hDEADBEEF, frz, reqc, addr_seen, we_seen, wd_seen);
    check_val("ld_freeze_cycles", 32'(frz), 32'd4);
    check_val("ld_req_cycles", 32'(reqc), 32'd3);
    check_val("ld_addr", 32'(addr_seen), 32'd2);
    check_val("ld_we", 32'(we_seen), 32'd0);
    check_val("ld_data_out", mem_data_out, 32'hDEADBEEF);
    check_val("ld_req_after", 32'(mem_req), 32'd0);

    // Store, immediate ack; load data must be preserved
    mem_w_en_in = 1'b1; alu_res_in = 32'd1024; val_rm_in = 32'h12345678;
    run_txn(0, 32'hCAFEF00D, frz, reqc, addr_seen, we_seen, wd_seen);
    check_val("st_freeze_cycles", 32'(frz), 32'd2);
    check_val("st_addr", 32'(addr_seen), 32'd0);
    check_val("st_we", 32'(we_seen), 32'd1);
    check_val("st_wdata", wd_seen, 32'h12345678);
    check_val("st_data_out_kept", mem_data_out, 32'hDEADBEEF);
    check_val("st_we_after", 32'(mem_we), 32'd0);

    // Non-memory op with a stray ack
    wb_en_in = 1'b1; dest_in = 4'd9; alu_res_in = 32'd777; mem_ack = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req || freeze) req_seen++;
      if (i == 1) begin
        check_val("nm_wb_en_out", 32'(wb_en_out), 32'd1);
        check_val("nm_dest_out", 32'(dest_out), 32'd9);
        check_val("nm_alu_res_out", alu_res_out, 32'd777);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    check_val("nm_no_req_or_freeze", 32'(req_seen), 32'd0);
    clear_inputs();

    // Timeout, address below base wraps
    mem_r_en_in = 1'b1; alu_res_in = 32'd1020;
    run_txn(-100, 32'h11111111, frz, reqc, addr_seen, we_seen, wd_seen);
    check_val("to_req_cycles", 32'(reqc), 32'd8);
    check_val("to_freeze_cycles", 32'(frz), 32'd9);
    check_val("to_addr_wrap", 32'(addr_seen), 32'h0000FFFF);
    check_val("to_mem_err", 32'(mem_err), 32'd1);
    check_val("to_data_out", mem_data_out, 32'd0);

    // Load after timeout still works; error stays sticky
    mem_r_en_in = 1'b1; alu_res_in = 32'd1028;
    run_txn(1, 32'h000055AA, frz, reqc, addr_seen, we_seen, wd_seen);
    check_val("post_to_freeze_cycles", 32'(frz), 32'd3);
    check_val("post_to_addr", 32'(addr_seen), 32'd1);
    check_val("post_to_data_out", mem_data_out, 32'h000055AA);
    check_val("post_to_mem_err", 32'(mem_err), 32'd1);

    // Both request bits: read wins
    mem_r_en_in = 1'b1; mem_w_en_in = 1'b1; alu_res_in = 32'd1040; val_rm_in = 32'hA5A5A5A5;
    run_txn(0, 32'h0BADCAFE, frz, reqc, addr_seen, we_seen, wd_seen);
    check_val("both_we", 32'(we_seen), 32'd0);
    check_val("both_addr", 32'(addr_seen), 32'd4);
    check_val("both_data_out", mem_data_out, 32'h0BADCAFE);

    // Reset during second WAIT cycle
    mem_r_en_in = 1'b1; wb_en_in = 1'b1; alu_res_in = 32'd1036; val_rm_in = 32'h77777777;
    @(negedge clk);
    check_val("rw_freeze_idle", 32'(freeze), 32'd1);
    check_val("rw_wb_en_out_frozen", 32'(wb_en_out), 32'd0);
    check_val("rw_mem_r_en_out_frozen", 32'(mem_r_en_out), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rw_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rw_req_async", 32'(mem_req), 32'd0);
    check_val("rw_freeze_async", 32'(freeze), 32'd0);
    clear_inputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rw_addr_cleared", 32'(mem_addr), 32'd0);
    check_val("rw_wdata_cleared", mem_wdata, 32'd0);
    check_val("rw_we_cleared", 32'(mem_we), 32'd0);
    check_val("rw_data_out_cleared", mem_data_out, 32'd0);
    check_val("rw_mem_err_cleared", 32'(mem_err), 32'd0);
    check_val("rw_freeze_after", 32'(freeze), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
